gf2m_reduce_131: RTL and testbench



---
 rtl/gf2m_reduce_131_if.sv | 13 +
 rtl/gf2m_reduce_131.sv | 63 ++++++
 tb/tb_gf2m_reduce_131.sv | 137 +++++++++++++
 3 files changed

// File: rtl/gf2m_reduce_131_if.sv
// gf2m_reduce_131_if: handshake bundle for the GF(2^131) reduction stage.
//   in_valid/in_ready/prod  : product input channel
//   out_valid/out_ready/r   : reduced result output channel
interface gf2m_reduce_131_if;
   logic         in_valid;
   logic         in_ready;
   logic [260:0] prod;
   logic         out_valid;
   logic         out_ready;
   logic [130:0] r;
   modport slave (input in_valid, prod, out_ready, output in_ready, out_valid, r);
   modport master(output in_valid, prod, out_ready, input in_ready, out_valid, r);
endinterface

// File: rtl/gf2m_reduce_131.sv
// gf2m_reduce_131: folds a 261-bit GF(2) product modulo x^131+x^13+x^2+x+1.
//   clk, rst : clock and synchronous active-high reset
//   io       : slave side of gf2m_reduce_131_if (prod in, r out, valid/ready both ways)
module gf2m_reduce_131 #(
   parameter int FOLD_BITS = 13
) (
   input logic             clk,
   input logic             rst,
   gf2m_reduce_131_if.slave io
);
   localparam int NUM_FOLDS = (130 + FOLD_BITS - 1) / FOLD_BITS;
   localparam int CW = $clog2(NUM_FOLDS + 1);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t        state;
   logic [260:0]  w, wf;
   logic [CW-1:0] cnt;
   int            hi, lo;
   assign io.in_ready = (state == IDLE) && !rst;
   // x^i = x^(i-131) * (x^13 + x^2 + x + 1); with FOLD_BITS <= 118 every
   // injected term lands below the current window, so it is picked up later.
   always_comb begin
      wf = w;
      hi = 260 - int'(cnt) * FOLD_BITS;
      lo = (hi - FOLD_BITS + 1 > 131) ? hi - FOLD_BITS + 1 : 131;
      for (int i = 260; i >= 131; i--)
         if (i <= hi && i >= lo && wf[i]) begin
            wf[i]     = 1'b0;
            wf[i-118] = ~wf[i-118];
            wf[i-129] = ~wf[i-129];
            wf[i-130] = ~wf[i-130];
            wf[i-131] = ~wf[i-131];
         end
   end
   always_ff @(posedge clk)
      if (rst) begin
         state        <= IDLE;
         io.out_valid <= 1'b0;
         io.r         <= '0;
         w            <= '0;
         cnt          <= '0;
      end else
         case (state)
            IDLE: if (io.in_valid) begin
               w     <= io.prod;
               cnt   <= '0;
               state <= BUSY;
            end
            BUSY: begin
               w   <= wf;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(NUM_FOLDS - 1)) begin
                  io.r         <= wf[130:0];
                  io.out_valid <= 1'b1;
                  state        <= DONE;
               end
            end
            DONE: if (io.out_ready) begin
               io.out_valid <= 1'b0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_gf2m_reduce_131.sv
// tb_gf2m_reduce_131: directed vectors, random products vs. long-division model, handshake corners.
module tb_gf2m_reduce_131;
   logic clk = 1'b0;
   logic rst;
   int   passed = 0, total = 0, cyc = 0;
   gf2m_reduce_131_if io();
   gf2m_reduce_131 dut(.clk(clk), .rst(rst), .io(io));
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   typedef struct {
      string        name;
      logic [260:0] p;
      logic [130:0] e;
   } vec_t;
   function automatic logic [130:0] ref_reduce(input logic [260:0] p);
      logic [260:0] a, f;
      a = p;
      f = '0;
      f[131] = 1'b1; f[13] = 1'b1; f[2] = 1'b1; f[1] = 1'b1; f[0] = 1'b1;
      for (int i = 260; i >= 131; i--)
         if (a[i]) a = a ^ (f << (i - 131));
      return a[130:0];
   endfunction
   function automatic logic [260:0] rand_prod();
      logic [287:0] t;
      for (int k = 0; k < 9; k++) t[k*32 +: 32] = $urandom;
      return t[260:0];
   endfunction
   task automatic chk(input string name, input logic [260:0] act, input logic [260:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask
   task automatic xact(input logic [260:0] p, output logic [130:0] res, output int lat, output int acc);
      io.prod = p;
      io.in_valid = 1'b1;
      @(posedge clk); #1;
      acc = cyc;
      io.in_valid = 1'b0;
      io.prod = ~p;
      lat = 0;
      while (!io.out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      res = io.r;
   endtask
   vec_t         tv[4];
   logic [260:0] p;
   logic [130:0] res, held;
   int           lat, acc, last;
   initial begin
      rst = 1'b1;
      io.in_valid = 1'b0;
      io.out_ready = 1'b0;
      io.prod = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("reset_out_valid", 261'(io.out_valid), 261'(0));
      chk("reset_r", 261'(io.r), 261'(0));
      chk("reset_in_ready", 261'(io.in_ready), 261'(1));
      p = '0; p[131] = 1'b1;
      tv[0] = '{"x131", p, 131'h2007};
      p = '0; p[260] = 1'b1;
      res = '0;
      res[130] = 1'b1; res[129] = 1'b1; res[24] = 1'b1; res[12] = 1'b1;
      res[11] = 1'b1; res[2] = 1'b1; res[1] = 1'b1; res[0] = 1'b1;
      tv[1] = '{"x260", p, res};
      p = '0; p[130:0] = '1;
      tv[2] = '{"all_ones_low", p, '1};
      p = '0;
      for (int i = 0; i <= 260; i += 2) p[i] = 1'b1;
      tv[3] = '{"square_ones", p, ref_reduce(p)};
      io.out_ready = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
         xact(tv[k].p, res, lat, acc);
         chk({tv[k].name, "_r"}, 261'(res), 261'(tv[k].e));
         chk({tv[k].name, "_lat"}, 261'(lat), 261'(10));
         @(posedge clk); #1;
      end
      last = -1;
      for (int k = 0; k < 1000; k++) begin
         p = rand_prod();
         xact(p, res, lat, acc);
         chk("rand_r", 261'(res), 261'(ref_reduce(p)));
         chk("rand_lat", 261'(lat), 261'(10));
         if (last >= 0) chk("rand_ii", 261'(acc - last), 261'(12));
         last = acc;
         @(posedge clk); #1;
      end
      io.out_ready = 1'b0;
      p = rand_prod();
      xact(p, res, lat, acc);
      held = res;
      chk("bp_r", 261'(res), 261'(ref_reduce(p)));
      for (int k = 0; k < 5; k++) begin
         io.in_valid = k[0];
         io.prod = rand_prod();
         @(posedge clk); #1;
         chk("bp_hold_r", 261'(io.r), 261'(held));
         chk("bp_hold_valid", 261'(io.out_valid), 261'(1));
         chk("bp_in_ready", 261'(io.in_ready), 261'(0));
      end
      io.in_valid = 1'b0;
      io.out_ready = 1'b1;
      @(posedge clk); #1;
      io.out_ready = 1'b0;
      chk("bp_release_valid", 261'(io.out_valid), 261'(0));
      chk("bp_release_ready", 261'(io.in_ready), 261'(1));
      chk("bp_release_r", 261'(io.r), 261'(held));
      repeat (3) @(posedge clk);
      #1 chk("bp_no_spurious", 261'(io.out_valid), 261'(0));
      p = '0; p[260] = 1'b1;
      io.prod = p;
      io.in_valid = 1'b1;
      @(posedge clk); #1;
      io.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready_low", 261'(io.in_ready), 261'(0));
      rst = 1'b0;
      #1;
      chk("rst_out_valid", 261'(io.out_valid), 261'(0));
      chk("rst_r", 261'(io.r), 261'(0));
      chk("rst_in_ready", 261'(io.in_ready), 261'(1));
      io.out_ready = 1'b1;
      xact(tv[0].p, res, lat, acc);
      chk("post_rst_r", 261'(res), 261'(131'h2007));
      chk("post_rst_lat", 261'(lat), 261'(10));
      @(posedge clk); #1;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
